// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmit and receive paths.
package uart_pkg;
  localparam int UART_DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;
endpackage

// File: rtl/sync_byte_fifo.sv
// Single-clock byte FIFO with first-word-fall-through read data and occupancy count.
module sync_byte_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push,
  input  logic [UART_DATA_BITS-1:0] wr_data,
  input  logic                      pop,
  output logic [UART_DATA_BITS-1:0] rd_data,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(DEPTH):0]    count
);
  localparam int AW = $clog2(DEPTH);

  logic [UART_DATA_BITS-1:0] mem [DEPTH];
  logic [AW-1:0]             wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]             rd_ptr_q, rd_ptr_d;
  logic [AW:0]               count_q, count_d;
  logic                      do_push, do_pop;

  // DEPTH is a power of two and count never exceeds it, so the MSB alone marks full.
  assign full    = count_q[AW];
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem[rd_ptr_q];

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: byte FIFO feeding a serialiser that sends
// queued frames back-to-back, LSB first.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic                          clk_100mhz,
  input  logic                          sys_rst_n,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          uart_txd,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int            CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int            NW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] TMR_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    BIT_LAST  = 3'(UART_DATA_BITS - 1);
  localparam logic          STOP_LAST = (STOP_BITS == 2);

  tx_state_t                 state_q, state_d;
  logic [CW-1:0]             timer_q, timer_d;
  logic [2:0]                bit_idx_q, bit_idx_d;
  logic                      stop_idx_q, stop_idx_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic                      txd_q, txd_d;
  logic                      busy_q, busy_d;
  logic                      tx_ready_q, tx_ready_d;

  logic [UART_DATA_BITS-1:0] fifo_rd_data;
  logic                      fifo_full, fifo_empty;
  logic [NW-1:0]             fifo_cnt, cnt_next;
  logic                      push, pop, bit_end;

  assign push    = tx_valid && tx_ready_q && !fifo_full;
  assign bit_end = (timer_q == TMR_LAST);

  sync_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk_100mhz),
    .rst_n   (sys_rst_n),
    .push    (push),
    .wr_data (tx_data),
    .pop     (pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_cnt)
  );

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    shift_d    = shift_q;
    txd_d      = txd_q;
    pop        = 1'b0;

    case (state_q)
      IDLE: begin
        txd_d = 1'b1;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_rd_data;
          timer_d = '0;
          txd_d   = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          timer_d   = '0;
          bit_idx_d = '0;
          txd_d     = shift_q[0];
          state_d   = DATA;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          timer_d = '0;
          if (bit_idx_q == BIT_LAST) begin
            stop_idx_d = 1'b0;
            txd_d      = 1'b1;
            state_d    = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
            shift_d   = shift_q >> 1;
            txd_d     = shift_q[1];
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          timer_d = '0;
          if (stop_idx_q == STOP_LAST) begin
            // Chain straight into the next start bit when more data is queued.
            if (!fifo_empty) begin
              pop     = 1'b1;
              shift_d = fifo_rd_data;
              txd_d   = 1'b0;
              state_d = START;
            end else begin
              txd_d   = 1'b1;
              state_d = IDLE;
            end
          end else begin
            stop_idx_d = stop_idx_q + 1'b1;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: begin
        txd_d   = 1'b1;
        state_d = IDLE;
      end
    endcase

    // Occupancy after this edge drives the registered ready and busy flags.
    case ({push, pop && !fifo_empty})
      2'b10:   cnt_next = fifo_cnt + 1'b1;
      2'b01:   cnt_next = fifo_cnt - 1'b1;
      default: cnt_next = fifo_cnt;
    endcase
    tx_ready_d = !cnt_next[NW-1];
    busy_d     = (state_d != IDLE) || (cnt_next != '0);
  end

  always_ff @(posedge clk_100mhz or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      shift_q    <= '0;
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
      tx_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      shift_q    <= shift_d;
      txd_q      <= txd_d;
      busy_q     <= busy_d;
      tx_ready_q <= tx_ready_d;
    end
  end

  assign uart_txd   = txd_q;
  assign busy       = busy_q;
  assign tx_ready   = tx_ready_q;
  assign fifo_count = fifo_cnt;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: one-stop-bit instance plus a two-stop-bit instance.
module tb_uart_tx_fifo;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] tx_data, tx_data2;
  logic       tx_valid, tx_valid2;
  logic       tx_ready, tx_ready2;
  logic       txd, txd2, busy, busy2;
  logic [2:0] count, count2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .STOP_BITS(1)) dut (
    .clk_100mhz (clk),
    .sys_rst_n  (rst_n),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .uart_txd   (txd),
    .busy       (busy),
    .fifo_count (count)
  );

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .STOP_BITS(2)) dut2 (
    .clk_100mhz (clk),
    .sys_rst_n  (rst_n),
    .tx_data    (tx_data2),
    .tx_valid   (tx_valid2),
    .tx_ready   (tx_ready2),
    .uart_txd   (txd2),
    .busy       (busy2),
    .fifo_count (count2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    repeat (n) tick();
  endtask

  // Walks one frame cycle by cycle from cycle index 'first'; ends on the cycle after the frame.
  task automatic frame_check(input logic [7:0] b, input int sb, input bit sel, input int first);
    int total;
    int bitn;
    logic exp;
    logic line;
    total = (9 + sb) * CPB;
    for (int i = first; i < total; i++) begin
      bitn = i / CPB;
      if (bitn == 0)      exp = 1'b0;
      else if (bitn <= 8) exp = b[bitn-1];
      else                exp = 1'b1;
      line = sel ? txd2 : txd;
      check($sformatf("txd byte %02h cyc %0d", b, i), line, exp);
      if (i == total - 1) check("busy on last stop cycle", sel ? busy2 : busy, 1);
      tick();
    end
    $display("frame %02h checked (stop bits %0d)", b, sb);
  endtask

  logic [7:0] seq [8];

  initial begin
    seq = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h54, 8'h65, 8'h76, 8'h87};
    rst_n = 1'b0; tx_valid = 1'b0; tx_valid2 = 1'b0; tx_data = '0; tx_data2 = '0;

    // Reset state
    tick_n(2);
    check("reset txd", txd, 1);
    check("reset busy", busy, 0);
    check("reset count", count, 0);
    check("reset tx_ready", tx_ready, 0);
    #3 rst_n = 1'b1;
    #1 check("tx_ready before first edge", tx_ready, 0);
    tick();
    check("tx_ready after release", tx_ready, 1);
    $display("reset released");

    // 1: single byte 0xA5
    tx_valid = 1'b1; tx_data = 8'hA5;
    tick();
    tx_valid = 1'b0; tx_data = 8'h00;
    check("t1 count after accept", count, 1);
    check("t1 busy after accept", busy, 1);
    check("t1 txd idle at accept", txd, 1);
    tick();
    check("t1 count after pop", count, 0);
    frame_check(8'hA5, 1, 1'b0, 0);
    check("t1 busy after frame", busy, 0);
    check("t1 txd after frame", txd, 1);

    // 2: three back-to-back bytes
    tx_valid = 1'b1; tx_data = 8'h01; tick();
    tx_data = 8'h02; tick();
    tx_data = 8'h03; tick();
    tx_valid = 1'b0;
    check("t2 count", count, 2);
    frame_check(8'h01, 1, 1'b0, 1);
    frame_check(8'h02, 1, 1'b0, 0);
    frame_check(8'h03, 1, 1'b0, 0);
    check("t2 busy after 120 cycles", busy, 0);

    // 3: hold valid with 8 bytes, FIFO fills and wraps
    fork
      begin
        bit rdy, acc;
        for (int j = 0; j < 8; j++) begin
          tx_valid = 1'b1; tx_data = seq[j];
          acc = 1'b0;
          for (int n = 0; n < 200 && !acc; n++) begin
            rdy = tx_ready;
            tick();
            if (rdy) acc = 1'b1;
          end
          check($sformatf("t3 accept byte %0d in time", j), acc, 1);
          $display("t3 byte %02h accepted=%0d", seq[j], acc);
          if (j == 4) begin
            check("t3 tx_ready low after 5 accepts", tx_ready, 0);
            check("t3 count full", count, 4);
          end
        end
        tx_valid = 1'b0;
      end
      begin
        tick_n(2);
        for (int k = 0; k < 8; k++) frame_check(seq[k], 1, 1'b0, 0);
      end
    join
    check("t3 busy after drain", busy, 0);

    // 4: push+pop at count 2, push blocked when full even with a pop
    tx_valid = 1'b1; tx_data = 8'hC1; tick();
    tx_data = 8'hC2; tick();
    tx_data = 8'hC3; tick();
    tx_valid = 1'b0;
    check("t4 count 2", count, 2);
    tick_n(38);
    tx_valid = 1'b1; tx_data = 8'hC4; tick();
    check("t4 count with push+pop", count, 2);
    check("t4 txd start of next frame", txd, 0);
    tx_data = 8'hC5; tick();
    check("t4 count 3", count, 3);
    tx_data = 8'hC6; tick();
    check("t4 count full", count, 4);
    check("t4 tx_ready when full", tx_ready, 0);
    tx_data = 8'hC7;
    tick_n(38);
    check("t4 count after pop while full", count, 3);
    check("t4 tx_ready after pop", tx_ready, 1);
    tx_valid = 1'b0;
    tick_n(159);
    check("t4 busy before drain end", busy, 1);
    tick();
    check("t4 busy after drain", busy, 0);
    check("t4 count after drain", count, 0);
    $display("t4 push/pop at count 2 and full-with-pop done");

    // 5: asynchronous reset mid-DATA
    tx_valid = 1'b1; tx_data = 8'h00; tick();
    tx_data = 8'h55; tick();
    tx_valid = 1'b0;
    tick_n(9);
    check("t5 txd low mid data", txd, 0);
    check("t5 count before reset", count, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t5 txd in reset", txd, 1);
    check("t5 busy in reset", busy, 0);
    check("t5 count in reset", count, 0);
    check("t5 tx_ready in reset", tx_ready, 0);
    #3 rst_n = 1'b1;
    tick();
    check("t5 tx_ready after release", tx_ready, 1);
    for (int i = 0; i < 20; i++) begin
      check("t5 txd idle after reset", txd, 1);
      check("t5 busy idle after reset", busy, 0);
      tick();
    end
    tx_valid = 1'b1; tx_data = 8'h3C; tick();
    tx_valid = 1'b0;
    tick();
    frame_check(8'h3C, 1, 1'b0, 0);
    check("t5 busy after recovery frame", busy, 0);

    // 6: two stop bits, 0xFF
    tx_valid2 = 1'b1; tx_data2 = 8'hFF; tick();
    tx_valid2 = 1'b0;
    tick();
    frame_check(8'hFF, 2, 1'b1, 0);
    check("t6 busy after 44 cycles", busy2, 0);
    check("t6 txd after frame", txd2, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
